// File: rtl/ms_fifo_ahbl.sv
// ms_fifo_ahbl
//   Word FIFO written by a DMA controller over AHB-Lite and drained as a
//   valid/ready stream. A low-level interrupt asks the DMAC to refill.
//
//   Register map (HADDR[7:0]):
//     0x00 DATA   W: push word, R: 0
//     0x04 STATUS R: {16'h0, LEVEL[7:0], 5'h0, OVF, FULL, EMPTY}
//     0x08 CTRL   RW: bit0 EN, bit1 FLUSH (write-1, reads 0), bit2 IE
//     0x0C THRESH RW: 8-bit IRQ threshold
//     others      R: 0xDEADBEEF, writes ignored
//
//   Ports:
//     HCLK, HRESETn                 clock, asynchronous active-low reset
//     HSEL..HWDATA                  AHB-Lite slave inputs
//     HREADYOUT, HRDATA             AHB-Lite slave outputs (HRESP always OKAY)
//     S_TDATA, S_TVALID, S_TREADY   stream head word / valid / consumer accept
//     IRQ                           IE & EN & (LEVEL <= THRESH)
//
//   Build option MS_FIFO_STALL_EN:
//     defined   - a DATA write to a full FIFO holds HREADYOUT low until a pop
//                 makes room, then the word is pushed.
//     undefined - a DATA write to a full FIFO is dropped and OVF is set
//                 (sticky until FLUSH or reset).
module ms_fifo_ahbl #(
  parameter int DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [31:0] S_TDATA,
  output logic        S_TVALID,
  input  logic        S_TREADY,
  output logic        IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_THRESH = 8'h0C;

  // Data-phase bookkeeping captured from the address phase
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [7:0]    dp_addr_q, dp_addr_d;

  // FIFO state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Control registers
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic [7:0]    thresh_q, thresh_d;

  // Storage, deliberately not reset
  logic [31:0]   mem [DEPTH];

  logic          data_wr, ctrl_wr, thresh_wr, flush;
  logic          full, empty, pop, push, room, stall, ovf_set;
  logic [8:0]    level_ext;
  logic [7:0]    level_sat;

  logic          unused_ok;
  assign unused_ok = ^{HADDR[31:8], HTRANS[0], HSIZE};

  always_comb begin
    data_wr   = dp_valid_q & dp_write_q & (dp_addr_q == A_DATA);
    ctrl_wr   = dp_valid_q & dp_write_q & (dp_addr_q == A_CTRL);
    thresh_wr = dp_valid_q & dp_write_q & (dp_addr_q == A_THRESH);
    flush     = ctrl_wr & HWDATA[1];

    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    pop   = en_q & ~empty & S_TREADY;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    room  = ~full | pop;
`ifdef MS_FIFO_STALL_EN
    stall   = data_wr & en_q & ~room;
    ovf_set = 1'b0;
`else
    stall   = 1'b0;
    ovf_set = data_wr & en_q & ~room;
`endif
    push = data_wr & en_q & room;
  end

  // Address-phase capture; held while the bus is stalled.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (HREADY) begin
      dp_valid_d = HSEL & HTRANS[1];
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[7:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | ovf_set;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    thresh_d = thresh_q;
    if (ctrl_wr) begin
      en_d = HWDATA[0];
      ie_d = HWDATA[2];
    end
    if (thresh_wr) thresh_d = HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      thresh_q   <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      thresh_q   <= thresh_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr_q] <= HWDATA;
  end

  // LEVEL needs 9 bits at DEPTH=256; the status field saturates at 255.
  always_comb begin
    level_ext = 9'(level_q);
    level_sat = level_ext[8] ? 8'hFF : level_ext[7:0];
  end

  // Read data is driven combinationally during the data phase so a read that
  // follows a write back-to-back sees that write's effect.
  always_comb begin
    HRDATA = 32'h0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        A_DATA:   HRDATA = 32'h0;
        A_STATUS: HRDATA = {16'h0, level_sat, 5'h0, ovf_q, full, empty};
        A_CTRL:   HRDATA = {29'h0, ie_q, 1'b0, en_q};
        A_THRESH: HRDATA = {24'h0, thresh_q};
        default:  HRDATA = 32'hDEAD_BEEF;
      endcase
    end
  end

  // The head is read combinationally so a pushed word is presented on the
  // cycle right after its data phase.
  always_comb begin
    HREADYOUT = ~stall;
    S_TVALID  = en_q & ~empty;
    S_TDATA   = mem[rd_ptr_q];
    IRQ       = ie_q & en_q & (level_ext <= {1'b0, thresh_q});
  end

endmodule

// File: tb/tb_ms_fifo_ahbl.sv
module tb_ms_fifo_ahbl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HADDR = 32'h0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic        HREADY;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [31:0] S_TDATA;
  logic        S_TVALID;
  logic        S_TREADY = 1'b0;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got[$];
  bit          collect = 1'b0;

  ms_fifo_ahbl #(.DEPTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .IRQ(IRQ)
  );

  // Single-slave bus: the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (collect && S_TVALID && S_TREADY) got.push_back(S_TDATA);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] data, output int waits);
    waits = 0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, addr}; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    while (HREADYOUT !== 1'b1 && waits < 50) begin
      @(posedge HCLK); #1;
      waits++;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    int w;
    ahb_write(addr, data, w);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, addr}; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
    n_checks++; if (S_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", S_TVALID); end
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd(8'h04, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL reset_status got=%h exp=00000001", r); end
    rd(8'h08, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", r); end
    rd(8'h0C, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_thresh got=%h exp=0", r); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [31:0] exp;
    wr(8'h08, 32'h1);
    S_TREADY = 1'b0;
    for (int i = 1; i <= 3; i++) wr(8'h00, 32'hA5A5_0000 + 32'(i));
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_0300) begin n_fail++; $display("FAIL basic_level3 got=%h exp=00000300", r); end
    n_checks++; if (S_TVALID !== 1'b1 || S_TDATA !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL basic_head got=%b/%h exp=1/a5a50001", S_TVALID, S_TDATA);
    end
    S_TREADY = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp = 32'hA5A5_0000 + 32'(i);
      n_checks++; if (S_TVALID !== 1'b1 || S_TDATA !== exp) begin
        n_fail++; $display("FAIL basic_pop%0d got=%b/%h exp=1/%h", i, S_TVALID, S_TDATA, exp);
      end
      @(posedge HCLK); #1;
    end
    S_TREADY = 1'b0;
    n_checks++; if (S_TVALID !== 1'b0) begin n_fail++; $display("FAIL basic_drained_tvalid got=%b exp=0", S_TVALID); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL basic_empty got=%h exp=00000001", r); end
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [31:0] act;
    int w;
    int n_exp;
    got.delete();
    collect = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h00, 32'h0F00_0000 + 32'(i));
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_full_status got=%h exp=00001002", r); end
`ifdef MS_FIFO_STALL_EN
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0F00_0010;
    n_checks++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL stall_start got=%b exp=0", HREADYOUT); end
    repeat (2) @(posedge HCLK);
    #1;
    n_checks++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL stall_hold got=%b exp=0", HREADYOUT); end
    S_TREADY = 1'b1;
    #1;
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", HREADYOUT); end
    @(posedge HCLK); #1;
    S_TREADY = 1'b0;
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL stall_after got=%b exp=1", HREADYOUT); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_1002) begin n_fail++; $display("FAIL stall_level16 got=%h exp=00001002", r); end
    n_exp = 17;
`else
    ahb_write(8'h00, 32'h0F00_0010, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL ovf_no_stall waits=%0d exp=0", w); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_1006) begin n_fail++; $display("FAIL ovf_status got=%h exp=00001006", r); end
    n_exp = 16;
`endif
    S_TREADY = 1'b1;
    repeat (20) @(posedge HCLK);
    #1;
    S_TREADY = 1'b0;
    collect = 1'b0;
    n_checks++; if (got.size() != n_exp) begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", got.size(), n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      n_checks++; if (act !== 32'h0F00_0000 + 32'(i)) begin
        n_fail++; $display("FAIL ovf_word%0d got=%h exp=%h", i, act, 32'h0F00_0000 + 32'(i));
      end
    end
    rd(8'h04, r);
`ifdef MS_FIFO_STALL_EN
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL ovf_end_status got=%h exp=00000001", r); end
`else
    n_checks++; if (r !== 32'h5) begin n_fail++; $display("FAIL ovf_sticky got=%h exp=00000005", r); end
`endif
    $display("test_overflow done");
  endtask

  task automatic test_flush();
    logic [31:0] r;
    for (int i = 0; i < 5; i++) wr(8'h00, 32'h0F10_0000 + 32'(i));
    rd(8'h04, r);
`ifdef MS_FIFO_STALL_EN
    n_checks++; if (r !== 32'h0000_0500) begin n_fail++; $display("FAIL flush_pre got=%h exp=00000500", r); end
`else
    n_checks++; if (r !== 32'h0000_0504) begin n_fail++; $display("FAIL flush_pre got=%h exp=00000504", r); end
`endif
    wr(8'h08, 32'h3);
    n_checks++; if (S_TVALID !== 1'b0) begin n_fail++; $display("FAIL flush_tvalid got=%b exp=0", S_TVALID); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL flush_status got=%h exp=00000001", r); end
    rd(8'h08, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL flush_ctrl got=%h exp=00000001", r); end
    $display("test_flush done");
  endtask

  task automatic test_irq();
    logic [31:0] r;
    logic        exp_irq;
    wr(8'h08, 32'h5);
    wr(8'h0C, 32'h2);
    rd(8'h0C, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL irq_thresh_rb got=%h exp=00000002", r); end
    rd(8'h08, r);
    n_checks++; if (r !== 32'h5) begin n_fail++; $display("FAIL irq_ctrl_rb got=%h exp=00000005", r); end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_level0 got=%b exp=1", IRQ); end
    for (int i = 1; i <= 3; i++) begin
      wr(8'h00, 32'h0E00_0000 + 32'(i));
      exp_irq = (i <= 2);
      n_checks++; if (IRQ !== exp_irq) begin n_fail++; $display("FAIL irq_level%0d got=%b exp=%b", i, IRQ, exp_irq); end
    end
    S_TREADY = 1'b1;
    @(posedge HCLK); #1;
    S_TREADY = 1'b0;
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_after_pop got=%b exp=1", IRQ); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_0200) begin n_fail++; $display("FAIL irq_level2 got=%h exp=00000200", r); end
    wr(8'h08, 32'h3);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_ie_off got=%b exp=0", IRQ); end
    $display("test_irq done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [31:0] act;
    logic [31:0] exp;
    int stalls;
    for (int i = 0; i < 16; i++) wr(8'h00, 32'h0B00_0000 + 32'(i));
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_1002) begin n_fail++; $display("FAIL b2b_full got=%h exp=00001002", r); end
    got.delete();
    collect = 1'b1;
    stalls = 0;
    S_TREADY = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge HCLK); #1;
      HWDATA = 32'h0C00_0000 + 32'(i);
      if (i == 39) begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      if (HREADYOUT !== 1'b1) stalls++;
    end
    @(posedge HCLK); #1;
    repeat (30) @(posedge HCLK);
    #1;
    S_TREADY = 1'b0;
    collect = 1'b0;
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
    n_checks++; if (got.size() != 56) begin n_fail++; $display("FAIL b2b_count got=%0d exp=56", got.size()); end
    for (int i = 0; i < 56; i++) begin
      exp = (i < 16) ? 32'h0B00_0000 + 32'(i) : 32'h0C00_0000 + 32'(i - 16);
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      n_checks++; if (act !== exp) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", i, act, exp); end
    end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL b2b_end_status got=%h exp=00000001", r); end
    $display("test_back_to_back done");
  endtask

  task automatic test_misc();
    logic [31:0] r;
    int w;
    rd(8'h20, r);
    n_checks++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misc_unmapped got=%h exp=deadbeef", r); end
    wr(8'h00, 32'h0D00_0001);
    wr(8'h00, 32'h0D00_0002);
    wr(8'h08, 32'h0);
    n_checks++; if (S_TVALID !== 1'b0) begin n_fail++; $display("FAIL misc_dis_tvalid got=%b exp=0", S_TVALID); end
    ahb_write(8'h00, 32'h0000_1234, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL misc_dis_stall waits=%0d exp=0", w); end
    rd(8'h04, r);
    n_checks++; if (r !== 32'h0000_0200) begin n_fail++; $display("FAIL misc_dis_level got=%h exp=00000200", r); end
    wr(8'h20, 32'hFFFF_FFFF);
    wr(8'h08, 32'h1);
    rd(8'h08, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL misc_ctrl got=%h exp=00000001", r); end
    n_checks++; if (S_TVALID !== 1'b1 || S_TDATA !== 32'h0D00_0001) begin
      n_fail++; $display("FAIL misc_retained got=%b/%h exp=1/0d000001", S_TVALID, S_TDATA);
    end
    $display("test_misc done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_irq();
    test_back_to_back();
    test_misc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
